// File: rtl/spi_device_core.sv
// SPI mode-0 device core: oversamples ss/sclk/sd on clk_i, one-deep RX and TX character
// buffers, and a small register file presented through the tlul_adapter_reg strobe interface.
module spi_device_core #(
    parameter int CharLen    = 8,
    parameter int SyncStages = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    input  logic        we_i,
    input  logic        re_i,
    output logic [31:0] rdata_o,
    output logic        error_o,
    output logic        intr_o,
    input  logic        ss_i,
    input  logic        sclk_i,
    input  logic        sd_i,
    output logic        sd_o,
    output logic        sd_oe_o
);

    localparam int CntW = (CharLen > 1) ? $clog2(CharLen) : 1;
    localparam logic [7:0] ADDR_TXDATA = 8'h00;
    localparam logic [7:0] ADDR_RXDATA = 8'h04;
    localparam logic [7:0] ADDR_STATUS = 8'h08;
    localparam logic [7:0] ADDR_CTRL   = 8'h0C;

    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state, state_next;

    logic [SyncStages-1:0] ss_sync, sclk_sync, sd_sync;
    logic                  ss_prev, sclk_prev;
    logic                  ss_s, sclk_s, sd_s;
    logic                  ss_fall, ss_rise, sclk_rise, sclk_fall;

    logic [2:0]            ctrl;
    logic [CharLen-1:0]    tx_hold, tx_shift, rx_shift, rx_data, rx_next, load_val;
    logic [CntW-1:0]       bit_cnt;
    logic                  tx_empty, tx_udr, rx_valid, rx_ovr, reload_pending, intr_q;
    logic                  reg_wr, reg_rd, tx_wr, rx_rd, st_wr, ctrl_wr;
    logic                  start, active_run, do_load, load_udr, char_done;
    logic                  unused_bits;

    assign unused_bits = ^{be_i, wdata_i};

    assign ss_s      = ss_sync[SyncStages-1];
    assign sclk_s    = sclk_sync[SyncStages-1];
    assign sd_s      = sd_sync[SyncStages-1];
    assign ss_fall   = ss_prev & ~ss_s;
    assign ss_rise   = ~ss_prev & ss_s;
    assign sclk_rise = ~sclk_prev & sclk_s;
    assign sclk_fall = sclk_prev & ~sclk_s;

    // Bus decode: illegal accesses flag error_o and are masked out of every side effect.
    always_comb begin
        error_o = (re_i | we_i) &
                  ((addr_i[1:0] != 2'b00) | (addr_i > ADDR_CTRL) | (we_i & (addr_i == ADDR_RXDATA)));
        reg_wr  = we_i & ~error_o;
        reg_rd  = re_i & ~error_o;
        tx_wr   = reg_wr & (addr_i == ADDR_TXDATA);
        st_wr   = reg_wr & (addr_i == ADDR_STATUS);
        ctrl_wr = reg_wr & (addr_i == ADDR_CTRL);
        rx_rd   = reg_rd & (addr_i == ADDR_RXDATA);
        rdata_o = '0;
        case (addr_i)
            ADDR_RXDATA: rdata_o[CharLen-1:0] = rx_data;
            ADDR_STATUS: rdata_o[4:0] = {state == ACTIVE, tx_udr, rx_ovr, tx_empty, rx_valid};
            ADDR_CTRL:   rdata_o[2:0] = ctrl;
            default:     rdata_o = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ss_fall && ctrl[0]) state_next = ACTIVE;
            ACTIVE:  if (ss_rise || !ctrl[0]) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        start      = (state == IDLE) && (state_next == ACTIVE);
        active_run = (state == ACTIVE) && (state_next == ACTIVE);
        // A TXDATA write landing on a reload is forwarded straight into the shifter.
        load_val   = tx_wr ? wdata_i[CharLen-1:0] : (tx_empty ? '1 : tx_hold);
        load_udr   = ~tx_wr & tx_empty;
        do_load    = start | (active_run & sclk_fall & reload_pending);
        char_done  = active_run & sclk_rise & (bit_cnt == CntW'(CharLen - 1));
        rx_next    = CharLen'({rx_shift, sd_s});
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ss_sync        <= '0;
            sclk_sync      <= '0;
            sd_sync        <= '0;
            ss_prev        <= 1'b0;
            sclk_prev      <= 1'b0;
            ctrl           <= '0;
            tx_hold        <= '0;
            tx_shift       <= '0;
            rx_shift       <= '0;
            rx_data        <= '0;
            bit_cnt        <= '0;
            tx_empty       <= 1'b1;
            tx_udr         <= 1'b0;
            rx_valid       <= 1'b0;
            rx_ovr         <= 1'b0;
            reload_pending <= 1'b0;
            intr_q         <= 1'b0;
        end else begin
            ss_sync   <= {ss_sync[SyncStages-2:0], ss_i};
            sclk_sync <= {sclk_sync[SyncStages-2:0], sclk_i};
            sd_sync   <= {sd_sync[SyncStages-2:0], sd_i};
            ss_prev   <= ss_s;
            sclk_prev <= sclk_s;

            if (ctrl_wr) ctrl <= wdata_i[2:0];

            if (tx_wr) begin
                tx_hold  <= wdata_i[CharLen-1:0];
                tx_empty <= 1'b0;
            end
            if (st_wr && wdata_i[3]) tx_udr <= 1'b0;
            if (do_load) begin
                tx_shift <= load_val;
                tx_empty <= 1'b1;
                if (load_udr) tx_udr <= 1'b1;
            end else if (active_run && sclk_fall) begin
                tx_shift <= tx_shift << 1;
            end

            if (start) begin
                bit_cnt        <= '0;
                reload_pending <= 1'b0;
            end else if (active_run && sclk_fall && reload_pending) begin
                reload_pending <= 1'b0;
            end

            if (active_run && sclk_rise) begin
                rx_shift <= rx_next;
                if (char_done) begin
                    rx_data        <= rx_next;
                    bit_cnt        <= '0;
                    reload_pending <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + CntW'(1);
                end
            end

            // Flag sets take priority over the read-clear and W1C paths.
            if (rx_rd) rx_valid <= 1'b0;
            if (st_wr && wdata_i[2]) rx_ovr <= 1'b0;
            if (char_done) begin
                rx_valid <= 1'b1;
                if (rx_valid && !rx_rd) rx_ovr <= 1'b1;
            end

            intr_q <= (ctrl[1] & rx_valid) | (ctrl[2] & (rx_ovr | tx_udr));
        end
    end

    assign intr_o  = intr_q;
    assign sd_oe_o = (state == ACTIVE);
    assign sd_o    = (state == ACTIVE) & tx_shift[CharLen-1];

endmodule
